cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle instruction sequencer for the 16-bit CPU. It fetches an instruction over a req/ack memory handshake and latches it into an internal IR. It then walks DECODE/EXEC/MEM/WB states, driving register-file read selects (5-bit, 0 = none), the one-hot register write enable, ALU op, flag enable, memory strobes and PC increment. It sits between instruction/data memory and the register file / ALU datapath.

Parameters:
DATA_W, 16, instruction and data width
NREG, 16, register count; one-hot write-enable width
SEL_W, 5, read-select width; value = reg index + 1, 0 = bus idle

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_rdata  in  16  memory read data
mem_ack  in  1  memory accepted/completed request; may assert same cycle as mem_req
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write qualifier for mem_req
addr_sel  out  1  0 = PC drives address, 1 = register bus A drives address
rsrc_sel  out  5  bus A read select
rdst_sel  out  5  bus B read select
rf_wen  out  16  one-hot register write enable
wb_sel  out  1  0 = ALU result, 1 = memory data
alu_op  out  4  ALU operation code
imm_sel  out  1  1 = sign-extended ir[7:0] replaces bus A operand
flag_en  out  1  flag register load strobe
pc_en  out  1  PC increment strobe
state_o  out  3  current state, debug

Behaviour:
- Format: ir[15:12] opcode, ir[11:8] rdst, ir[7:4] ext/imm-hi, ir[3:0] rsrc/imm-lo.
- Supported instructions:
  - Opcode 0000 R-type, ext: AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101; ext 0000 = NOP.
  - Immediate forms use opcode = R ext code, with imm_sel=1.
  - Opcode 0100: ext 0000 LOAD rdst,[rsrc]; ext 0100 STOR rdst,[rsrc].
  - Any other encoding is NOP.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ack, IR <= mem_rdata and go to DECODE. No ack means stay.
- DECODE: all strobes 0.
  - ALU ops and imm ops go to EXEC.
  - LOAD/STOR go to MEM.
  - NOP: pc_en=1, go to FETCH.
- EXEC:
  - Drives rdst_sel=ir[11:8]+1, alu_op.
  - rsrc_sel=ir[3:0]+1 for R-type; for immediate forms rsrc_sel=0 and imm_sel=1.
  - flag_en=1 for ADD, SUB, CMP.
  - CMP: pc_en=1, go to FETCH (no WB). All others go to WB.
- MEM: mem_req=1, addr_sel=1, rsrc_sel=ir[3:0]+1.
  - STOR: mem_we=1, rdst_sel=ir[11:8]+1; on ack, pc_en=1 and go to FETCH.
  - LOAD: on ack, go to WB.
  - Selects are held stable while waiting for ack.
- WB: rf_wen = 1<<ir[11:8] for exactly one cycle; wb_sel=1 if LOAD else 0; alu_op/selects held from EXEC; pc_en=1; go to FETCH.
- Latency with zero-wait ack:
  - ALU op: 4 cycles.
  - CMP: 3 cycles.
  - LOAD: 4 cycles.
  - STOR: 3 cycles.
  - NOP: 2 cycles.
- Invariants:
  - rf_wen is zero outside WB and never has more than one bit set.
  - pc_en pulses exactly once per instruction.
  - mem_req is never asserted in DECODE, EXEC or WB.
- Reset: asynchronous on reset_n=0.
  - state=FETCH, IR=0x0000 (NOP).
  - While asserted, all outputs are held 0, including mem_req, rf_wen and pc_en.
  - Reset mid-MEM drops mem_req immediately with no write commit.
  - After release, the first cycle is FETCH with mem_req=1.
- Unused ALU op states drive alu_op=0000.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode and ext constants;
  - state encoding;
  - alu_op encoding (AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101);
  - SEL_NONE=5'd0.
- One sub-module, reg_idx_decode: 4-bit index in, 5-bit select (idx+1) and 16-bit one-hot out. It is instantiated twice (src and dst); the controller gates its outputs by state.

Test Plan:
- ADD r3,r5 (0x0355), ack tied high → states 0,1,2,4,0. EXEC: rsrc_sel=6, rdst_sel=4, alu_op=0101, flag_en=1. WB: rf_wen=0x0008, wb_sel=0. One pc_en, in WB.
- ADDI r2,#-1 (0x52FF) → EXEC: imm_sel=1, rsrc_sel=0, rdst_sel=3. WB: rf_wen=0x0004.
- LOAD r15,[r0] (0x4F00), ack delayed 3 cycles → mem_req/addr_sel=1 held 3 cycles with rsrc_sel=1, then WB: rf_wen=0x8000, wb_sel=1.
- STOR r1,[r4] (0x4144) → MEM: mem_we=1, rsrc_sel=5, rdst_sel=2. rf_wen stays 0 throughout; pc_en on the ack cycle.
- CMP r7,r7 (0x07B7), plus illegal 0xF123 → CMP: flag_en=1, no WB, 3 cycles. Illegal: treated as NOP, 2 cycles, no flag_en or rf_wen.
- reset_n low during MEM of a STOR with ack withheld → mem_req/mem_we drop immediately, no write. After release: state 0, IR=0, first fetch mem_req=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control path: states, opcodes, ALU codes and
// the instruction-class decoder used by the sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STOR = 4'h4;

  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_AND  = 4'h1;
  localparam logic [3:0] ALU_OR   = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_ADD  = 4'h5;
  localparam logic [3:0] ALU_SUB  = 4'h9;
  localparam logic [3:0] ALU_CMP  = 4'hB;
  localparam logic [3:0] ALU_MOV  = 4'hD;

  localparam logic [4:0] SEL_NONE = 5'd0;

  typedef enum logic [2:0] {
    K_NOP,
    K_ALU,
    K_IMM,
    K_LOAD,
    K_STOR
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] alu_op;
  } dec_t;

  function automatic logic is_alu_code(input logic [3:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_CMP, ALU_MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Immediate forms reuse the R-type ext code as their opcode.
  function automatic dec_t decode_ir(input logic [3:0] opcode, input logic [3:0] ext);
    dec_t d;
    d.kind   = K_NOP;
    d.alu_op = ALU_NONE;
    if (opcode == OP_RTYPE) begin
      if (is_alu_code(ext)) begin
        d.kind   = K_ALU;
        d.alu_op = ext;
      end
    end else if (opcode == OP_MEM) begin
      if (ext == EXT_LOAD) d.kind = K_LOAD;
      else if (ext == EXT_STOR) d.kind = K_STOR;
    end else if (is_alu_code(opcode)) begin
      d.kind   = K_IMM;
      d.alu_op = opcode;
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_idx_decode.sv
// Register index to bus select (index + 1, zero reserved for idle) and
// one-hot write-enable vector.
module reg_idx_decode #(
  parameter int SEL_W = 5,
  parameter int NREG  = 16
) (
  input  logic [3:0]       idx_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [NREG-1:0]  onehot_o
);

  assign sel_o    = SEL_W'(idx_i) + SEL_W'(1);
  assign onehot_o = NREG'(1) << idx_i;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch over req/ack, then DECODE/EXEC/MEM/WB
// driving register-file selects, write enable, ALU op, memory strobes and PC step.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              addr_sel,
  output logic [SEL_W-1:0]  rsrc_sel,
  output logic [SEL_W-1:0]  rdst_sel,
  output logic [NREG-1:0]   rf_wen,
  output logic              wb_sel,
  output logic [3:0]        alu_op,
  output logic              imm_sel,
  output logic              flag_en,
  output logic              pc_en,
  output logic [2:0]        state_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  dec_t              dec;
  logic [SEL_W-1:0]  src_sel, dst_sel;
  logic [NREG-1:0]   dst_onehot, src_onehot_unused;

  assign dec     = decode_ir(ir_q[15:12], ir_q[7:4]);
  assign state_o = state_q;

  reg_idx_decode #(.SEL_W(SEL_W), .NREG(NREG)) u_src_dec (
    .idx_i    (ir_q[3:0]),
    .sel_o    (src_sel),
    .onehot_o (src_onehot_unused)
  );

  reg_idx_decode #(.SEL_W(SEL_W), .NREG(NREG)) u_dst_dec (
    .idx_i    (ir_q[11:8]),
    .sel_o    (dst_sel),
    .onehot_o (dst_onehot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (dec.kind)
          K_ALU, K_IMM:   state_d = S_EXEC;
          K_LOAD, K_STOR: state_d = S_MEM;
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXEC:  state_d = (dec.alu_op == ALU_CMP) ? S_FETCH : S_WB;
      S_MEM: begin
        if (mem_ack) state_d = (dec.kind == K_STOR) ? S_FETCH : S_WB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are Moore-style except the STOR completion pulse, and are all
  // forced low while reset is asserted so a reset mid-MEM kills the request.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    rsrc_sel = SEL_NONE;
    rdst_sel = SEL_NONE;
    rf_wen   = '0;
    wb_sel   = 1'b0;
    alu_op   = ALU_NONE;
    imm_sel  = 1'b0;
    flag_en  = 1'b0;
    pc_en    = 1'b0;
    case (state_q)
      S_FETCH:  mem_req = 1'b1;
      S_DECODE: pc_en   = (dec.kind == K_NOP);
      S_EXEC: begin
        rdst_sel = dst_sel;
        rsrc_sel = (dec.kind == K_IMM) ? SEL_NONE : src_sel;
        imm_sel  = (dec.kind == K_IMM);
        alu_op   = dec.alu_op;
        flag_en  = (dec.alu_op == ALU_ADD) || (dec.alu_op == ALU_SUB) ||
                   (dec.alu_op == ALU_CMP);
        pc_en    = (dec.alu_op == ALU_CMP);
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        rsrc_sel = src_sel;
        if (dec.kind == K_STOR) begin
          mem_we   = 1'b1;
          rdst_sel = dst_sel;
          pc_en    = mem_ack;
        end
      end
      S_WB: begin
        rf_wen = dst_onehot;
        pc_en  = 1'b1;
        if (dec.kind == K_LOAD) begin
          wb_sel = 1'b1;
        end else begin
          rdst_sel = dst_sel;
          rsrc_sel = (dec.kind == K_IMM) ? SEL_NONE : src_sel;
          imm_sel  = (dec.kind == K_IMM);
          alu_op   = dec.alu_op;
        end
      end
      default: ;
    endcase
    if (!reset_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      rsrc_sel = SEL_NONE;
      rdst_sel = SEL_NONE;
      rf_wen   = '0;
      wb_sel   = 1'b0;
      alu_op   = ALU_NONE;
      imm_sel  = 1'b0;
      flag_en  = 1'b0;
      pc_en    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: per-cycle expected output words queued from a small
// reference model, plus a table of per-instruction summary expectations.
module tb_cpu_ctrl_fsm;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, addr_sel, wb_sel, imm_sel, flag_en, pc_en;
  logic [4:0]  rsrc_sel, rdst_sel;
  logic [15:0] rf_wen;
  logic [3:0]  alu_op;
  logic [2:0]  state_o;

  cpu_ctrl_fsm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .rsrc_sel  (rsrc_sel),
    .rdst_sel  (rdst_sel),
    .rf_wen    (rf_wen),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .imm_sel   (imm_sel),
    .flag_en   (flag_en),
    .pc_en     (pc_en),
    .state_o   (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [39:0] exp_q[$];
  logic        ack_q[$];
  logic [15:0] data_q[$];

  logic [15:0] acc_rfw;
  logic        acc_flag;
  int          pc_cnt;

  typedef struct {
    logic [15:0] instr;
    int          mwait;
    logic [15:0] exp_rfw;
    logic        exp_flag;
  } vec_t;

  vec_t vecs[13];

  // {state, mem_req, mem_we, addr_sel, rsrc, rdst, rf_wen, wb_sel, alu_op, imm, flag, pc}
  function automatic logic [39:0] pk(input logic [2:0] st, input logic req, input logic we,
                                     input logic asel, input logic [4:0] rs, input logic [4:0] rd,
                                     input logic [15:0] rfw, input logic wbs, input logic [3:0] aop,
                                     input logic imm, input logic flg, input logic pc);
    return {st, req, we, asel, rs, rd, rfw, wbs, aop, imm, flg, pc};
  endfunction

  function automatic logic [39:0] dut_word();
    return pk(state_o, mem_req, mem_we, addr_sel, rsrc_sel, rdst_sel, rf_wen,
              wb_sel, alu_op, imm_sel, flag_en, pc_en);
  endfunction

  function automatic logic valid_code(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h2) || (c == 4'h3) || (c == 4'h5) ||
           (c == 4'h9) || (c == 4'hB) || (c == 4'hD);
  endfunction

  task automatic push_cyc(input logic [39:0] w, input logic a, input logic [15:0] d);
    exp_q.push_back(w);
    ack_q.push_back(a);
    data_q.push_back(d);
  endtask

  // Reference model: expected output word and ack stimulus for every cycle.
  task automatic predict(input logic [15:0] instr, input int fwait, input int mwait);
    logic [3:0]  op, ext, rd, rs, aop;
    logic [4:0]  rs1, rd1, ex_rs;
    logic [15:0] one, oh;
    logic        imm, flg, cmp;
    int          kind;  // 0 nop, 1 alu, 2 imm, 3 load, 4 stor
    op  = instr[15:12];
    rd  = instr[11:8];
    ext = instr[7:4];
    rs  = instr[3:0];
    rs1 = {1'b0, rs} + 5'd1;
    rd1 = {1'b0, rd} + 5'd1;
    one = 16'd1;
    oh  = one << rd;
    aop = 4'h0;
    kind = 0;
    if (op == 4'h0) begin
      if (valid_code(ext)) begin kind = 1; aop = ext; end
    end else if (op == 4'h4) begin
      if (ext == 4'h0) kind = 3;
      else if (ext == 4'h4) kind = 4;
    end else if (valid_code(op)) begin
      kind = 2; aop = op;
    end
    for (int i = 0; i < fwait; i++)
      push_cyc(pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 16'($urandom));
    push_cyc(pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, instr);
    push_cyc(pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, kind == 0), 1'($urandom_range(0, 1)), 16'($urandom));
    if (kind == 1 || kind == 2) begin
      imm   = (kind == 2);
      ex_rs = imm ? 5'd0 : rs1;
      flg   = (aop == 4'h5) || (aop == 4'h9) || (aop == 4'hB);
      cmp   = (aop == 4'hB);
      push_cyc(pk(3'd2, 0, 0, 0, ex_rs, rd1, 0, 0, aop, imm, flg, cmp), 1'($urandom_range(0, 1)), 16'($urandom));
      if (!cmp)
        push_cyc(pk(3'd4, 0, 0, 0, ex_rs, rd1, oh, 0, aop, imm, 0, 1), 1'($urandom_range(0, 1)), 16'($urandom));
    end else if (kind == 3) begin
      for (int i = 0; i < mwait; i++)
        push_cyc(pk(3'd3, 1, 0, 1, rs1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 16'($urandom));
      push_cyc(pk(3'd3, 1, 0, 1, rs1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'($urandom));
      push_cyc(pk(3'd4, 0, 0, 0, 0, 0, oh, 1, 0, 0, 0, 1), 1'($urandom_range(0, 1)), 16'($urandom));
    end else if (kind == 4) begin
      for (int i = 0; i < mwait; i++)
        push_cyc(pk(3'd3, 1, 1, 1, rs1, rd1, 0, 0, 0, 0, 0, 0), 1'b0, 16'($urandom));
      push_cyc(pk(3'd3, 1, 1, 1, rs1, rd1, 0, 0, 0, 0, 0, 1), 1'b1, 16'($urandom));
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare settled outputs.
  task automatic run_cycle(input logic a, input logic [15:0] d, input string tag);
    logic [39:0] act, e;
    @(negedge clk);
    mem_ack   = a;
    mem_rdata = d;
    #1;
    act = dut_word();
    acc_rfw  = acc_rfw | rf_wen;
    acc_flag = acc_flag | flag_en;
    pc_cnt   = pc_cnt + int'(pc_en);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected entry, actual word %h", tag, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s: cycle word actual %h expected %h", tag, act, e);
      end
    end
  endtask

  task automatic do_instr(input logic [15:0] instr, input int fwait, input int mwait);
    string tag;
    tag = $sformatf("instr_%h", instr);
    acc_rfw  = '0;
    acc_flag = 1'b0;
    pc_cnt   = 0;
    predict(instr, fwait, mwait);
    while (ack_q.size() > 0)
      run_cycle(ack_q.pop_front(), data_q.pop_front(), tag);
    n_checks++;
    if (pc_cnt != 1) begin
      n_errors++;
      $display("FAIL %s pc_en_count: actual %0d expected 1", tag, pc_cnt);
    end
  endtask

  task automatic check_word(input string tag, input logic [39:0] e);
    n_checks++;
    if (dut_word() !== e) begin
      n_errors++;
      $display("FAIL %s: actual %h expected %h", tag, dut_word(), e);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h0355, 0, 16'h0008, 1'b1};  // ADD r3,r5
    vecs[1]  = '{16'h52FF, 0, 16'h0004, 1'b1};  // ADDI r2,#-1
    vecs[2]  = '{16'h4F00, 3, 16'h8000, 1'b0};  // LOAD r15,[r0], 3 wait cycles
    vecs[3]  = '{16'h4144, 0, 16'h0000, 1'b0};  // STOR r1,[r4]
    vecs[4]  = '{16'h4144, 2, 16'h0000, 1'b0};  // STOR with wait
    vecs[5]  = '{16'h07B7, 0, 16'h0000, 1'b1};  // CMP r7,r7
    vecs[6]  = '{16'hF123, 0, 16'h0000, 1'b0};  // illegal opcode
    vecs[7]  = '{16'h0000, 0, 16'h0000, 1'b0};  // NOP
    vecs[8]  = '{16'h0D12, 0, 16'h2000, 1'b0};  // AND r13,r2
    vecs[9]  = '{16'h1A3C, 0, 16'h0400, 1'b0};  // ANDI r10
    vecs[10] = '{16'h0A7E, 0, 16'h0000, 1'b0};  // bad R ext -> NOP
    vecs[11] = '{16'h4E21, 0, 16'h0000, 1'b0};  // bad mem ext -> NOP
    vecs[12] = '{16'h9000, 1, 16'h0001, 1'b1};  // SUBI r0

    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    #3;
    check_word("reset_outputs_zero", 40'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_instr(vecs[i].instr, i % 2, vecs[i].mwait);
      n_checks++;
      if (acc_rfw !== vecs[i].exp_rfw) begin
        n_errors++;
        $display("FAIL vec%0d rf_wen_union: actual %h expected %h", i, acc_rfw, vecs[i].exp_rfw);
      end
      n_checks++;
      if (acc_flag !== vecs[i].exp_flag) begin
        n_errors++;
        $display("FAIL vec%0d flag_en_seen: actual %b expected %b", i, acc_flag, vecs[i].exp_flag);
      end
    end

    for (int k = 0; k < 24; k++) begin
      logic [3:0] ops[10];
      logic [3:0] exts[10];
      logic [15:0] ins;
      ops  = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h1, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
      exts = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hD, 4'h7};
      ins = {ops[$urandom_range(0, 9)], 4'($urandom), exts[$urandom_range(0, 9)], 4'($urandom)};
      do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset while a STOR is waiting in MEM: request and write must drop at once.
    push_cyc(pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'h4144);
    push_cyc(pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 16'h0);
    push_cyc(pk(3'd3, 1, 1, 1, 5'd5, 5'd2, 0, 0, 0, 0, 0, 0), 1'b0, 16'h0);
    push_cyc(pk(3'd3, 1, 1, 1, 5'd5, 5'd2, 0, 0, 0, 0, 0, 0), 1'b0, 16'h0);
    while (ack_q.size() > 0)
      run_cycle(ack_q.pop_front(), data_q.pop_front(), "stor_before_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check_word("reset_mid_mem_drop", 40'h0);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    check_word("reset_held_zero", 40'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    reset_n = 1'b1;
    #1;
    check_word("first_fetch_after_reset", pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    n_checks++;
    if (dut.ir_q !== 16'h0000) begin
      n_errors++;
      $display("FAIL ir_after_reset: actual %h expected 0000", dut.ir_q);
    end
    do_instr(16'h0355, 0, 0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_expected: actual %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
